tail_light_seq: RTL and testbench
=================================

// Module: tail_light_seq
// PURPOSE
//   Parametrised tail-light sequencer; the next generation of the 3+3 turn-signal FSM.
//   Drives LAMPS lamps per side with progressive turn sequences at a prescaled step rate.
//   Adds a hazard mode: both sides flash together.
//   Sits between the switch/debounce inputs and the lamp driver pins on the board top level.
// PARAMETERS
//   LAMPS  3  lamps per side, >=2.
//   DIV    4  clk cycles per sequence step, >=1; DIV=1 steps on every clk edge.
// PORTS
//   clk      in   1      single system clock; all logic on its rising edge
//   reset_n  in   1      synchronous, active-low reset
//   left     in   1      left turn request, level
//   right    in   1      right turn request, level
//   hazard   in   1      hazard request, level
//   lamp_l   out  LAMPS  left lamps; bit0 innermost, bit LAMPS-1 outermost; 1 = lit
//   lamp_r   out  LAMPS  right lamps; same bit ordering as lamp_l
//   busy     out  1      1 whenever state != IDLE
// BEHAVIOUR
//   Reset
//   - reset_n==0 at an edge: state=IDLE, step=0, prescaler=0, lamp_l=0, lamp_r=0, busy=0.
//   - Applies at any point, including mid-sequence; no partial completion afterwards.
//   Prescaler (tick)
//   - Counter 0..DIV-1, free-running after reset.
//   - tick=1 when cnt==DIV-1; cnt then wraps to 0.
//   - DIV=1: tick is constant 1.
//   - Counter width is max(1,$clog2(DIV)).
//   State changes and input sampling
//   - State, step and lamps change ONLY on edges where tick=1.
//   - Inputs are sampled only on those edges; requests shorter than one tick period may be missed.
//   - All outputs are registers.
//   - Latency: the request is sampled at tick edge t; lamps update at that same edge t.
//   States: IDLE, LSEQ, RSEQ, HAZ_ON, HAZ_OFF. step counts 1..LAMPS.
//   - IDLE
//     - hazard | (left & right) -> HAZ_ON
//     - else left -> LSEQ, step=1
//     - else right -> RSEQ, step=1
//     - else stay in IDLE
//   - LSEQ
//     - lamp_l = (1<<step)-1, lamp_r = 0.
//     - step<LAMPS: step+1.
//     - step==LAMPS: -> IDLE, all lamps off for one step.
//   - RSEQ: mirror of LSEQ on lamp_r.
//   - HAZ_ON
//     - all bits of lamp_l and lamp_r = 1.
//     - -> HAZ_OFF.
//   - HAZ_OFF
//     - all lamps 0.
//     - hazard | (left & right) -> HAZ_ON
//     - else -> IDLE
//   Priority and simultaneous events
//   - hazard preempts LSEQ/RSEQ: if sampled high at a tick in LSEQ/RSEQ, go to HAZ_ON (step cleared).
//   - left/right changes during LSEQ/RSEQ are ignored; the sequence runs to completion.
//   - Opposite-side requests are honoured only from IDLE.
//   - left & right together is hazard, in every state where hazard is checked.
//   Illegal state encoding -> IDLE on the next tick.
// STRUCTURE
//   - Shared package tail_light_pkg: state encoding constants (IDLE, LSEQ, RSEQ, HAZ_ON, HAZ_OFF)
//     and the state width, so driver/test code can decode busy/state.
//   - Sub-module tick_gen #(DIV) (clk, reset_n, tick): the prescaler.
//   - This module: state/step registers, next-state logic, registered lamp decode.
// TESTING (LAMPS=3 unless noted)
//   - DIV=1; left=1 for one cycle:
//     lamp_l 001,011,111,000 on 4 consecutive edges; lamp_r=000 throughout; busy 1,1,1,0.
//   - DIV=1; right held high:
//     lamp_r 001,011,111,000,001... repeats with one off step between; lamp_l=000.
//   - DIV=1; left=right=1:
//     both sides 111 then 000, alternating; after release, HAZ_OFF -> IDLE, lamps 000.
//   - DIV=1; left started, hazard=1 while lamp_l=011:
//     next edge both sides 111 (HAZ_ON); left sequence abandoned.
//   - DIV=4; left pulse held 4 cycles:
//     lamp_l changes only every 4th edge (001 for 4 cycles, then 011 ...);
//     a 1-cycle pulse between ticks is ignored.
//   - DIV=1; reset_n=0 for 1 cycle while lamp_r=011:
//     lamps 000, busy=0 at that edge; no further steps without a new request.
//     Repeat with LAMPS=5: lamp_l runs 00001..11111.

Source files
------------

// File: rtl/tail_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_pkg
// Description : State encoding shared by the tail-light sequencer and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package tail_light_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t LSEQ    = 3'd1;
    localparam state_t RSEQ    = 3'd2;
    localparam state_t HAZ_ON  = 3'd3;
    localparam state_t HAZ_OFF = 3'd4;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running prescaler; tick pulses once every DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_div1
            assign tick = 1'b1;
        end else begin : g_divn
            localparam int CNT_W = $clog2(DIV);
            localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_LAST) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign tick = (r_cnt == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module      : tail_light_seq
// Description : Progressive turn / hazard tail-light sequencer, LAMPS per side.
// Revision    : 1.0 - initial release
// ============================================================================
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS = 3,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r,
    output logic             busy
);

    localparam int STEP_W = $clog2(LAMPS + 1);
    localparam logic [STEP_W-1:0] C_STEP_MAX = STEP_W'(LAMPS);
    localparam logic [STEP_W-1:0] C_STEP_ONE = STEP_W'(1);

    logic              w_tick;
    logic              w_haz_req;
    logic [STEP_W-1:0] w_step_inc;
    state_t            r_state;
    logic [STEP_W-1:0] r_step;

    // Thermometer pattern: the n innermost lamps lit.
    function automatic logic [LAMPS-1:0] fill(input logic [STEP_W-1:0] n);
        logic [LAMPS-1:0] v;
        for (int i = 0; i < LAMPS; i++) begin
            v[i] = (i < int'(n));
        end
        return v;
    endfunction

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (w_tick)
    );

    // Both turn requests together are treated as a hazard request.
    assign w_haz_req  = hazard | (left & right);
    assign w_step_inc = r_step + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_step  <= '0;
            lamp_l  <= '0;
            lamp_r  <= '0;
            busy    <= 1'b0;
        end else if (w_tick) begin
            lamp_l <= '0;
            lamp_r <= '0;
            busy   <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_step <= '0;
                    if (w_haz_req) begin
                        r_state <= HAZ_ON;
                        lamp_l  <= '1;
                        lamp_r  <= '1;
                    end else if (left) begin
                        r_state <= LSEQ;
                        r_step  <= C_STEP_ONE;
                        lamp_l  <= fill(C_STEP_ONE);
                    end else if (right) begin
                        r_state <= RSEQ;
                        r_step  <= C_STEP_ONE;
                        lamp_r  <= fill(C_STEP_ONE);
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LSEQ, RSEQ: begin
                    if (w_haz_req) begin
                        r_state <= HAZ_ON;
                        r_step  <= '0;
                        lamp_l  <= '1;
                        lamp_r  <= '1;
                    end else if (r_step < C_STEP_MAX) begin
                        r_step <= w_step_inc;
                        if (r_state == LSEQ) begin
                            lamp_l <= fill(w_step_inc);
                        end else begin
                            lamp_r <= fill(w_step_inc);
                        end
                    end else begin
                        // Final step leaves all lamps dark for one step period.
                        r_state <= IDLE;
                        r_step  <= '0;
                        busy    <= 1'b0;
                    end
                end
                HAZ_ON: begin
                    r_state <= HAZ_OFF;
                    r_step  <= '0;
                end
                HAZ_OFF: begin
                    r_step <= '0;
                    if (w_haz_req) begin
                        r_state <= HAZ_ON;
                        lamp_l  <= '1;
                        lamp_r  <= '1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_step  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tail_light_seq
// Description : Scoreboard bench for tail_light_seq across three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tail_light_seq;

    localparam int M_IDLE  = 0;
    localparam int M_LEFT  = 1;
    localparam int M_RIGHT = 2;
    localparam int M_LIT   = 3;
    localparam int M_DARK  = 4;

    // Expected entry per DUT: {busy, lamp_l[7:0], lamp_r[7:0]}
    typedef logic [2:0][16:0] trio_t;

    logic clk;
    logic reset_n;
    logic left;
    logic right;
    logic hazard;

    logic [2:0] l0, r0, l1, r1;
    logic [4:0] l2, r2;
    logic       b0, b1, b2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit live     = 0;

    int nl[3] = '{3, 3, 5};
    int nd[3] = '{1, 4, 1};
    int m_mode[3];
    int m_n[3];
    int m_k[3];

    trio_t q[$];

    tail_light_seq #(.LAMPS(3), .DIV(1)) u_d0 (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
        .lamp_l(l0), .lamp_r(r0), .busy(b0));
    tail_light_seq #(.LAMPS(3), .DIV(4)) u_d1 (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
        .lamp_l(l1), .lamp_r(r1), .busy(b1));
    tail_light_seq #(.LAMPS(5), .DIV(1)) u_d2 (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
        .lamp_l(l2), .lamp_r(r2), .busy(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sequence step of the behavioural model, in terms of "n lamps lit".
    task automatic model_step(input int lamps, input bit l, input bit r, input bit h,
                              input int mode_i, input int n_i,
                              output int mode_o, output int n_o);
        bit hz;
        hz = h | (l & r);
        mode_o = mode_i;
        n_o    = n_i;
        case (mode_i)
            M_IDLE: begin
                n_o = 0;
                if (hz)     mode_o = M_LIT;
                else if (l) begin mode_o = M_LEFT;  n_o = 1; end
                else if (r) begin mode_o = M_RIGHT; n_o = 1; end
            end
            M_LEFT, M_RIGHT: begin
                if (hz)              begin mode_o = M_LIT;  n_o = 0; end
                else if (n_i < lamps) n_o = n_i + 1;
                else                 begin mode_o = M_IDLE; n_o = 0; end
            end
            M_LIT:   mode_o = M_DARK;
            default: mode_o = hz ? M_LIT : M_IDLE;
        endcase
    endtask

    function automatic logic [7:0] side_lamps(input int mode, input int n,
                                              input int lamps, input int side);
        if (mode == side)  return 8'((1 << n) - 1);
        if (mode == M_LIT) return 8'((1 << lamps) - 1);
        return 8'd0;
    endfunction

    always @(posedge clk) begin
        trio_t e;
        int    nm, nn;
        cyc = cyc + 1;
        if (!reset_n) live = 1;
        if (live) begin
            for (int d = 0; d < 3; d++) begin
                if (!reset_n) begin
                    m_mode[d] = M_IDLE;
                    m_n[d]    = 0;
                    m_k[d]    = 0;
                end else begin
                    m_k[d] = m_k[d] + 1;
                    if (m_k[d] % nd[d] == 0) begin
                        model_step(nl[d], left, right, hazard, m_mode[d], m_n[d], nm, nn);
                        m_mode[d] = nm;
                        m_n[d]    = nn;
                    end
                end
                e[d] = {(m_mode[d] != M_IDLE),
                        side_lamps(m_mode[d], m_n[d], nl[d], M_LEFT),
                        side_lamps(m_mode[d], m_n[d], nl[d], M_RIGHT)};
            end
            q.push_back(e);
        end
    end

    task automatic check(input string name, input int d, input logic [7:0] act,
                         input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s dut%0d cycle=%0d got=%b expected=%b", name, d, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        trio_t e;
        trio_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a[0] = {b0, {5'd0, l0}, {5'd0, r0}};
            a[1] = {b1, {5'd0, l1}, {5'd0, r1}};
            a[2] = {b2, {3'd0, l2}, {3'd0, r2}};
            for (int d = 0; d < 3; d++) begin
                check("lamp_l", d, a[d][15:8], e[d][15:8]);
                check("lamp_r", d, a[d][7:0],  e[d][7:0]);
                check("busy",   d, {7'd0, a[d][16]}, {7'd0, e[d][16]});
            end
        end
    end

    task automatic hold(input bit l, input bit r, input bit h, input int n);
        left   = l;
        right  = r;
        hazard = h;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        hazard  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        hold(0, 0, 0, 2);
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 8);
        hold(0, 1, 0, 14);
        hold(1, 1, 0, 7);
        hold(0, 0, 0, 4);
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 1);
        hold(0, 0, 1, 1);
        hold(0, 0, 0, 6);
        hold(1, 0, 0, 4);
        hold(0, 0, 0, 2);
        hold(0, 1, 0, 1);
        hold(0, 0, 0, 12);
        hold(0, 1, 0, 2);
        reset_n = 1'b0;
        hold(0, 0, 0, 1);
        reset_n = 1'b1;
        hold(0, 0, 0, 6);
        for (int seg = 0; seg < 40; seg++) begin
            int pl, pr, ph, pc;
            pl = $urandom_range(0, 70);
            pr = $urandom_range(0, 70);
            ph = $urandom_range(0, 15);
            pc = $urandom_range(5, 60);
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 99) < pc) left   = ($urandom_range(0, 99) < pl);
                if ($urandom_range(0, 99) < pc) right  = ($urandom_range(0, 99) < pr);
                if ($urandom_range(0, 99) < pc) hazard = ($urandom_range(0, 99) < ph);
                reset_n = ($urandom_range(0, 299) != 0);
            end
        end
        reset_n = 1'b1;
        hold(0, 0, 0, 10);
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
